// File: rtl/pif_pkg.sv
// Shared encodings for the PIF LED flasher and its monitor.
package pif_pkg;

  // Ramp phase encodings, shared with the flasher's phase field.
  // Bit 0 is the direction (0 = rising, 1 = falling), bit 1 selects the LED.
  localparam logic [1:0] PH_RED_UP = 2'd0;
  localparam logic [1:0] PH_RED_DN = 2'd1;
  localparam logic [1:0] PH_GRN_UP = 2'd2;
  localparam logic [1:0] PH_GRN_DN = 2'd3;

  // Monitor FSM states.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FLUSH   = 2'd1,
    ST_MEASURE = 2'd2
  } state_e;

endpackage

// File: rtl/pif_sync.sv
// Parameterized-depth single-bit synchronizer for an asynchronous input.
module pif_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  // Shift the raw input through the flop chain; the oldest stage is the output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ff <= '0;
    end else begin
      ff <= (ff << 1) | STAGES'(d);
    end
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/pif_led_monitor.sv
// Observes the flasher's active-low red/green pins, measures per-window
// on-counts (duty) and recovers the ramp phase from the window-to-window trend.
//
// Handshake: valid is a one-cycle strobe with no back-pressure; duty_red,
// duty_green, phase, conflict and dim change only in the cycle valid is high
// and hold their values until the next strobe.
//
// The FSM state is kept in the 'state' signal for observation.
module pif_led_monitor
  import pif_pkg::*;
#(
  parameter int WBITS       = 5,
  parameter int SYNC_STAGES = 2
) (
  input  logic           Clk,
  input  logic           sys_rst,
  input  logic           en,
  input  logic           red,
  input  logic           green,
  output logic [WBITS:0] duty_red,
  output logic [WBITS:0] duty_green,
  output logic [1:0]     phase,
  output logic           valid,
  output logic           conflict,
  output logic           dim
);

  localparam int FW = (SYNC_STAGES > 1) ? $clog2(SYNC_STAGES) : 1;
  localparam logic [FW-1:0]    FLAST = FW'(SYNC_STAGES - 1);
  localparam logic [WBITS-1:0] WMAX  = '1;

  state_e           state;
  state_e           state_nxt;
  logic             red_s;
  logic             green_s;
  logic             on_r;
  logic             on_g;
  logic [FW-1:0]    fcnt;
  logic [WBITS-1:0] wcnt;
  logic [WBITS:0]   cnt_r;
  logic [WBITS:0]   cnt_g;
  logic [WBITS:0]   fin_r;
  logic [WBITS:0]   fin_g;
  logic [WBITS:0]   prev_r;
  logic [WBITS:0]   prev_g;
  logic             have_prev;
  logic             win_end;
  logic [1:0]       ph_nxt;

  pif_sync #(.STAGES(SYNC_STAGES)) u_sync_red (
    .clk (Clk),
    .rst (sys_rst),
    .d   (red),
    .q   (red_s)
  );

  pif_sync #(.STAGES(SYNC_STAGES)) u_sync_green (
    .clk (Clk),
    .rst (sys_rst),
    .d   (green),
    .q   (green_s)
  );

  // Pins are active-low: a synchronized 0 is an on-sample.
  assign on_r  = ~red_s;
  assign on_g  = ~green_s;
  // Final counts include the current cycle's sample.
  assign fin_r = cnt_r + (WBITS+1)'(on_r);
  assign fin_g = cnt_g + (WBITS+1)'(on_g);

  // FSM state register.
  always_ff @(posedge Clk or posedge sys_rst) begin
    if (sys_rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic and window-end detection; dropping en aborts from any state.
  always_comb begin
    state_nxt = state;
    win_end   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (en) state_nxt = ST_FLUSH;
      end
      ST_FLUSH: begin
        if (!en)                state_nxt = ST_IDLE;
        else if (fcnt == FLAST) state_nxt = ST_MEASURE;
      end
      ST_MEASURE: begin
        if (!en) state_nxt = ST_IDLE;
        else     win_end   = (wcnt == WMAX);
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Phase decode from the trend of the single lit LED; conflict/dim windows
  // leave the phase alone, and an equal count keeps the direction bit.
  always_comb begin
    ph_nxt = phase;
    if (fin_r != '0 && fin_g == '0) begin
      if (!have_prev || fin_r > prev_r) ph_nxt = PH_RED_UP;
      else if (fin_r < prev_r)          ph_nxt = PH_RED_DN;
      else                              ph_nxt = {1'b0, phase[0]};
    end else if (fin_g != '0 && fin_r == '0) begin
      if (!have_prev || fin_g > prev_g) ph_nxt = PH_GRN_UP;
      else if (fin_g < prev_g)          ph_nxt = PH_GRN_DN;
      else                              ph_nxt = {1'b1, phase[0]};
    end
  end

  // Flush, window and on-counters; windows run back to back with no gap.
  always_ff @(posedge Clk or posedge sys_rst) begin
    if (sys_rst) begin
      fcnt  <= '0;
      wcnt  <= '0;
      cnt_r <= '0;
      cnt_g <= '0;
    end else begin
      if (state == ST_FLUSH && state_nxt == ST_FLUSH) fcnt <= fcnt + 1'b1;
      else                                            fcnt <= '0;
      if (state == ST_MEASURE && en) begin
        wcnt  <= wcnt + 1'b1;
        cnt_r <= win_end ? '0 : fin_r;
        cnt_g <= win_end ? '0 : fin_g;
      end else begin
        wcnt  <= '0;
        cnt_r <= '0;
        cnt_g <= '0;
      end
    end
  end

  // Output and trend registers, loaded only at a completed window end.
  always_ff @(posedge Clk or posedge sys_rst) begin
    if (sys_rst) begin
      duty_red   <= '0;
      duty_green <= '0;
      phase      <= PH_RED_UP;
      valid      <= 1'b0;
      conflict   <= 1'b0;
      dim        <= 1'b0;
      prev_r     <= '0;
      prev_g     <= '0;
      have_prev  <= 1'b0;
    end else begin
      valid <= win_end;
      if (win_end) begin
        duty_red   <= fin_r;
        duty_green <= fin_g;
        conflict   <= (fin_r != '0) && (fin_g != '0);
        dim        <= (fin_r == '0) && (fin_g == '0);
        phase      <= ph_nxt;
        prev_r     <= fin_r;
        prev_g     <= fin_g;
        have_prev  <= 1'b1;
      end else if (state_nxt == ST_IDLE) begin
        have_prev  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pif_led_monitor.sv
// Directed bench for pif_led_monitor: window duties, phase trend, flags,
// strobe timing, enable abort and asynchronous reset.
module tb_pif_led_monitor;
  import pif_pkg::*;

  localparam int WBITS = 5;
  localparam int SYNC  = 2;
  localparam int WLEN  = 1 << WBITS;
  localparam int RW    = 16;

  logic           Clk;
  logic           sys_rst;
  logic           en;
  logic           red;
  logic           green;
  logic [WBITS:0] duty_red;
  logic [WBITS:0] duty_green;
  logic [1:0]     phase;
  logic           valid;
  logic           conflict;
  logic           dim;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int e0       = 0;
  int wins     = 0;

  logic [RW-1:0] exp_q[$];
  logic [RW-1:0] obs_q[$];
  int            exp_cyc_q[$];
  int            obs_cyc_q[$];

  pif_led_monitor #(.WBITS(WBITS), .SYNC_STAGES(SYNC)) dut (
    .Clk        (Clk),
    .sys_rst    (sys_rst),
    .en         (en),
    .red        (red),
    .green      (green),
    .duty_red   (duty_red),
    .duty_green (duty_green),
    .phase      (phase),
    .valid      (valid),
    .conflict   (conflict),
    .dim        (dim)
  );

  // Clock and edge counter.
  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  always @(posedge Clk) cyc <= cyc + 1;

  // Record every strobe with the edge number it followed.
  always @(posedge Clk) begin
    #1;
    if (valid) begin
      obs_q.push_back({duty_red, duty_green, phase, conflict, dim});
      obs_cyc_q.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Drive one cycle of pin levels (arguments are on-flags) and pass one edge.
  task automatic step(input logic r_on, input logic g_on);
    red   = ~r_on;
    green = ~g_on;
    @(posedge Clk);
    #1;
  endtask

  // Raise en; the following edge is edge 0 of the run.
  task automatic start_run;
    en   = 1'b1;
    e0   = cyc + 1;
    wins = 0;
    step(1'b0, 1'b0);
  endtask

  // One window of pin activity: red on for nr cycles, green on for ng cycles.
  task automatic frame(input int nr, input int ng);
    for (int i = 0; i < WLEN; i++) step(i < nr, i < ng);
  endtask

  // Expected strobe for the next window of the current run.
  task automatic expect_win(input int dr, input int dg, input logic [1:0] ph,
                            input logic c, input logic d);
    exp_q.push_back({6'(dr), 6'(dg), ph, c, d});
    exp_cyc_q.push_back(e0 + 1 + SYNC + WLEN - 1 + wins * WLEN);
    wins++;
  endtask

  task automatic check_outputs(input string tag, input int dr, input int dg,
                               input logic [1:0] ph, input logic c, input logic d);
    check({tag, "_duty_red"},   32'(duty_red),   32'(dr));
    check({tag, "_duty_green"}, 32'(duty_green), 32'(dg));
    check({tag, "_phase"},      32'(phase),      32'(ph));
    check({tag, "_conflict"},   32'(conflict),   32'(c));
    check({tag, "_dim"},        32'(dim),        32'(d));
  endtask

  initial begin
    sys_rst = 1'b1;
    en      = 1'b0;
    red     = 1'b1;
    green   = 1'b1;
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    check_outputs("reset", 0, 0, 2'd0, 1'b0, 1'b0);
    check("reset_valid", 32'(valid), 32'd0);
    check("reset_state", 32'(dut.state), 32'(ST_IDLE));
    sys_rst = 1'b0;
    step(1'b0, 1'b0);

    // Static red.
    start_run;
    frame(32, 0);              expect_win(32, 0, PH_RED_UP, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0);
    en = 1'b0;
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0);

    // Red ramp, green ramp, overlap, off, then a green window before abort.
    start_run;
    frame(8, 0);               expect_win(8, 0, PH_RED_UP, 1'b0, 1'b0);
    frame(12, 0);              expect_win(12, 0, PH_RED_UP, 1'b0, 1'b0);
    frame(6, 0);               expect_win(6, 0, PH_RED_DN, 1'b0, 1'b0);
    frame(0, 10);              expect_win(0, 10, PH_GRN_UP, 1'b0, 1'b0);
    frame(0, 4);               expect_win(0, 4, PH_GRN_DN, 1'b0, 1'b0);
    frame(0, 4);               expect_win(0, 4, PH_GRN_DN, 1'b0, 1'b0);
    frame(3, 5);               expect_win(3, 5, PH_GRN_DN, 1'b1, 1'b0);
    frame(0, 0);               expect_win(0, 0, PH_GRN_DN, 1'b0, 1'b1);
    frame(0, 20);              expect_win(0, 20, PH_GRN_UP, 1'b0, 1'b0);
    // Partial window with red on; en dropped around wcnt 17.
    for (int i = 0; i < 18; i++) step(1'b1, 1'b0);
    en = 1'b0;
    for (int i = 0; i < 40; i++) step(1'b1, 1'b0);
    check_outputs("abort_hold", 0, 20, PH_GRN_UP, 1'b0, 1'b0);

    // Re-raise: a lower green count must still read as rising.
    start_run;
    frame(0, 10);              expect_win(0, 10, PH_GRN_UP, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0);
    en = 1'b0;
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0);

    // Asynchronous reset mid-window with red on.
    start_run;
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0);
    #3 sys_rst = 1'b1;
    #1;
    check_outputs("midrst", 0, 0, 2'd0, 1'b0, 1'b0);
    check("midrst_valid", 32'(valid), 32'd0);
    check("midrst_state", 32'(dut.state), 32'(ST_IDLE));
    en = 1'b0;
    step(1'b0, 1'b0);
    sys_rst = 1'b0;
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0);

    // Scoreboard: strobe contents and timing, nothing extra while en is low.
    check("strobe_count", 32'(obs_q.size()), 32'(exp_q.size()));
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      logic [RW-1:0] e_rec;
      logic [RW-1:0] o_rec;
      int            e_cy;
      int            o_cy;
      e_rec = exp_q.pop_front();
      o_rec = obs_q.pop_front();
      e_cy  = exp_cyc_q.pop_front();
      o_cy  = obs_cyc_q.pop_front();
      check("win_duty_red",   32'(o_rec[15:10]), 32'(e_rec[15:10]));
      check("win_duty_green", 32'(o_rec[9:4]),   32'(e_rec[9:4]));
      check("win_phase",      32'(o_rec[3:2]),   32'(e_rec[3:2]));
      check("win_conflict",   32'(o_rec[1]),     32'(e_rec[1]));
      check("win_dim",        32'(o_rec[0]),     32'(e_rec[0]));
      check("win_edge",       32'(o_cy),         32'(e_cy));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
